// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

  localparam int unsigned PC_STEP   = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fetch_buffer.sv
// One-entry IF/ID register: load from fetch, consume by decode, flush on redirect.
module fetch_buffer #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic                  i_consume,
  input  logic                  i_flush,
  input  logic [DATA_WIDTH-1:0] i_instr,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  input  logic [ADDR_WIDTH-1:0] i_pc_plus4,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic [ADDR_WIDTH-1:0] o_pc_plus4
);
  import mips_fetch_pkg::*;

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_instr;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_pc_plus4;

  // Flush wins over load; a reload on the consume edge keeps the entry valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_instr    <= DATA_WIDTH'(NOP_INSTR);
      r_pc       <= '0;
      r_pc_plus4 <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid    <= 1'b1;
      r_instr    <= i_instr;
      r_pc       <= i_pc;
      r_pc_plus4 <= i_pc_plus4;
    end else if (i_consume) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid    = r_valid;
  assign o_instr    = r_instr;
  assign o_pc       = r_pc;
  assign o_pc_plus4 = r_pc_plus4;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding imem request, drives the PC register, fills IF/ID.
// state | meaning
// FETCH | request pc_in when the IF/ID buffer is free
// WAIT  | request accepted, response will load the buffer
// DROP  | request squashed by redirect, response is discarded
module instruction_fetch #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PC_STEP    = mips_fetch_pkg::PC_STEP
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  output logic                  pc_enable,
  output logic [ADDR_WIDTH-1:0] next_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_resp_valid,
  input  logic [DATA_WIDTH-1:0] imem_resp_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [DATA_WIDTH-1:0] id_instr,
  output logic [ADDR_WIDTH-1:0] id_pc,
  output logic [ADDR_WIDTH-1:0] id_pc_plus4,
  output logic                  fetch_misaligned
);
  import mips_fetch_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);

  fetch_state_t          r_state;
  fetch_state_t          w_state_next;
  logic [ADDR_WIDTH-1:0] r_req_pc;
  logic                  r_misaligned;
  logic                  w_buf_free;
  logic                  w_req_fire;
  logic                  w_load;

  assign w_buf_free = !id_valid || id_ready;
  assign w_req_fire = imem_req_valid && imem_req_ready;
  assign imem_addr  = {pc_in[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    w_state_next   = r_state;
    imem_req_valid = 1'b0;
    pc_enable      = 1'b0;
    next_pc        = '0;
    w_load         = 1'b0;
    if (redirect_valid) begin
      pc_enable = 1'b1;
      next_pc   = redirect_pc;
      if (r_state == WAIT || r_state == DROP)
        w_state_next = imem_resp_valid ? FETCH : DROP;
      else
        w_state_next = FETCH;
    end else begin
      case (r_state)
        FETCH: begin
          imem_req_valid = w_buf_free;
          if (w_buf_free && imem_req_ready) begin
            pc_enable    = 1'b1;
            next_pc      = pc_in + STEP;
            w_state_next = WAIT;
          end
        end
        WAIT: begin
          if (imem_resp_valid) begin
            w_load       = 1'b1;
            w_state_next = FETCH;
          end
        end
        DROP: begin
          if (imem_resp_valid) w_state_next = FETCH;
        end
        default: w_state_next = FETCH;
      endcase
    end
    // Keep the PC and memory quiet while reset is held.
    if (reset) begin
      imem_req_valid = 1'b0;
      pc_enable      = 1'b0;
      next_pc        = '0;
      w_load         = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= FETCH;
      r_req_pc     <= '0;
      r_misaligned <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_req_fire) begin
        r_req_pc     <= pc_in;
        r_misaligned <= |pc_in[1:0];
      end
    end
  end

  assign fetch_misaligned = r_misaligned;

  fetch_buffer #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fetch_buffer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_consume  (id_valid && id_ready),
    .i_flush    (redirect_valid),
    .i_instr    (imem_resp_data),
    .i_pc       (r_req_pc),
    .i_pc_plus4 (r_req_pc + STEP),
    .o_valid    (id_valid),
    .o_instr    (id_instr),
    .o_pc       (id_pc),
    .o_pc_plus4 (id_pc_plus4)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a PC register model and a latency-programmable memory.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic        pc_enable;
  logic [31:0] next_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        fetch_misaligned;

  logic [31:0] pc_rst_val;
  int          lat;
  logic        mem_pend;
  int          mem_cnt;
  logic [31:0] mem_paddr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk              (clk),
    .reset            (reset),
    .pc_in            (pc_in),
    .pc_enable        (pc_enable),
    .next_pc          (next_pc),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_addr        (imem_addr),
    .imem_resp_valid  (imem_resp_valid),
    .imem_resp_data   (imem_resp_data),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .id_valid         (id_valid),
    .id_ready         (id_ready),
    .id_instr         (id_instr),
    .id_pc            (id_pc),
    .id_pc_plus4      (id_pc_plus4),
    .fetch_misaligned (fetch_misaligned)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    if (a == 32'h4) return 32'h2009_0007;
    return {16'hC0DE, a[15:0]};
  endfunction

  // Program counter register model.
  always @(posedge clk or posedge reset) begin
    if (reset) pc_in <= pc_rst_val;
    else if (pc_enable) pc_in <= next_pc;
  end

  // Memory: lat==0 answers in the cycle after accept, lat==N adds N cycles.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_pend        <= 1'b0;
      mem_cnt         <= 0;
      mem_paddr       <= 32'h0;
      imem_resp_valid <= 1'b0;
      imem_resp_data  <= 32'h0;
    end else begin
      imem_resp_valid <= 1'b0;
      if (mem_pend) begin
        if (mem_cnt <= 1) begin
          imem_resp_valid <= 1'b1;
          imem_resp_data  <= mem_word(mem_paddr);
          mem_pend        <= 1'b0;
        end else begin
          mem_cnt <= mem_cnt - 1;
        end
      end else if (imem_req_valid && imem_req_ready) begin
        if (lat == 0) begin
          imem_resp_valid <= 1'b1;
          imem_resp_data  <= mem_word(imem_addr);
        end else begin
          mem_pend  <= 1'b1;
          mem_cnt   <= lat;
          mem_paddr <= imem_addr;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    pc_rst_val     = 32'h0;
    lat            = 0;
    imem_req_ready = 1'b1;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    #3;
    check("rst_id_valid",  id_valid, 0);
    check("rst_pc_en",     pc_enable, 0);
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_misalign",  fetch_misaligned, 0);
    check("rst_id_instr",  id_instr, 0);

    @(negedge clk); reset = 1'b0; #1;
    check("first_req_valid", imem_req_valid, 1);
    check("first_addr",      imem_addr, 32'h0);
    check("first_pc_en",     pc_enable, 1);
    check("first_next_pc",   next_pc, 32'h4);

    @(negedge clk);
    check("wait_no_req",   imem_req_valid, 0);
    check("wait_no_pc_en", pc_enable, 0);
    check("pc_adv_4",      pc_in, 32'h4);

    @(negedge clk);
    check("i0_valid", id_valid, 1);
    check("i0_instr", id_instr, 32'h2008_0005);
    check("i0_pc",    id_pc, 32'h0);
    check("i0_pc4",   id_pc_plus4, 32'h4);
    check("i1_addr",  imem_addr, 32'h4);
    check("i1_req",   imem_req_valid, 1);

    @(negedge clk);
    check("i0_consumed", id_valid, 0);
    @(negedge clk);
    check("i1_valid", id_valid, 1);
    check("i1_instr", id_instr, 32'h2009_0007);
    check("i1_pc",    id_pc, 32'h4);
    check("i1_pc4",   id_pc_plus4, 32'h8);

    @(negedge clk); id_ready = 1'b0;
    @(negedge clk);
    check("stall_valid", id_valid, 1);
    check("stall_pc_in", pc_in, 32'hC);
    for (int i = 0; i < 5; i++) begin
      check("stall_no_req", imem_req_valid, 0);
      check("stall_pc_en",  pc_enable, 0);
      check("stall_instr",  id_instr, 32'hC0DE_0008);
      check("stall_pc",     id_pc, 32'h8);
      @(negedge clk);
    end
    id_ready = 1'b1; lat = 3; #1;
    check("unstall_req",     imem_req_valid, 1);
    check("unstall_addr",    imem_addr, 32'hC);
    check("unstall_next_pc", next_pc, 32'h10);

    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
    check("redir_pc_en",   pc_enable, 1);
    check("redir_next_pc", next_pc, 32'h100);
    check("redir_no_req",  imem_req_valid, 0);
    @(negedge clk); redirect_valid = 1'b0; lat = 0;
    check("redir_pc_in", pc_in, 32'h100);
    for (int i = 0; i < 3; i++) begin
      check("drop_no_req", imem_req_valid, 0);
      check("drop_no_id",  id_valid, 0);
      @(negedge clk);
    end
    check("post_drop_req",  imem_req_valid, 1);
    check("post_drop_addr", imem_addr, 32'h100);
    @(negedge clk);
    @(negedge clk);
    check("tgt_valid", id_valid, 1);
    check("tgt_instr", id_instr, 32'hC0DE_0100);
    check("tgt_pc",    id_pc, 32'h100);

    redirect_valid = 1'b1; redirect_pc = 32'h10; #1;
    check("fredir_no_req",  imem_req_valid, 0);
    check("fredir_next_pc", next_pc, 32'h10);
    @(negedge clk); redirect_valid = 1'b0; imem_req_ready = 1'b0; #1;
    check("fredir_flush", id_valid, 0);
    for (int i = 0; i < 3; i++) begin
      check("hold_req",   imem_req_valid, 1);
      check("hold_addr",  imem_addr, 32'h10);
      check("hold_pc_en", pc_enable, 0);
      check("hold_pc_in", pc_in, 32'h10);
      @(negedge clk);
    end
    imem_req_ready = 1'b1; lat = 3; #1;
    check("accept_pc_en",   pc_enable, 1);
    check("accept_next_pc", next_pc, 32'h14);

    @(negedge clk);
    check("midwait_no_req", imem_req_valid, 0);
    check("midwait_pc_in",  pc_in, 32'h14);
    reset = 1'b1; pc_rst_val = 32'hFFFF_FFFC; lat = 0; #1;
    check("midrst_id_valid", id_valid, 0);
    check("midrst_pc_en",    pc_enable, 0);
    @(negedge clk); reset = 1'b0; #1;
    check("wrap_req",     imem_req_valid, 1);
    check("wrap_addr",    imem_addr, 32'hFFFF_FFFC);
    check("wrap_next_pc", next_pc, 32'h0);
    @(negedge clk);
    check("wrap_pc_in", pc_in, 32'h0);
    check("midrst_resp_ignored", id_valid, 0);
    @(negedge clk);
    check("wrap_id_pc",  id_pc, 32'hFFFF_FFFC);
    check("wrap_id_pc4", id_pc_plus4, 32'h0);
    check("wrap_instr",  id_instr, 32'hC0DE_FFFC);
    lat = 3;

    @(negedge clk);
    reset = 1'b1; pc_rst_val = 32'h6; #1;
    check("rst2_id_valid", id_valid, 0);
    check("rst2_misalign", fetch_misaligned, 0);
    @(negedge clk); reset = 1'b0; lat = 0; #1;
    check("mis_req",        imem_req_valid, 1);
    check("mis_addr",       imem_addr, 32'h4);
    check("mis_pre_issue",  fetch_misaligned, 0);
    @(negedge clk);
    check("mis_flag",  fetch_misaligned, 1);
    check("mis_pc_in", pc_in, 32'hA);
    @(negedge clk);
    check("mis_id_instr", id_instr, 32'h2009_0007);
    check("mis_id_pc",    id_pc, 32'h6);
    check("mis_id_pc4",   id_pc_plus4, 32'hA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage sitting directly downstream of the program counter register (ports clk, reset, enable, newPC, PC) and upstream of decode.
- Reads the current PC and issues one instruction-memory request at a time.
- Drives the PC's enable/newPC with PC+4 or a redirect target.
- Holds the fetched word in a one-entry IF/ID buffer with a valid/ready handshake to decode.

Parameters:
- ADDR_WIDTH, 32, width of PC and memory address
- DATA_WIDTH, 32, instruction word width
- PC_STEP, 4, sequential PC increment in bytes

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- pc_in  in  ADDR_WIDTH  current PC from program counter
- pc_enable  out  1  load strobe to program counter (its enable)
- next_pc  out  ADDR_WIDTH  value loaded into program counter (its newPC)
- imem_req_valid  out  1  memory request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  ADDR_WIDTH  word-aligned request address
- imem_resp_valid  in  1  response data valid, one pulse per accepted request
- imem_resp_data  in  DATA_WIDTH  instruction word
- redirect_valid  in  1  branch/jump/exception redirect
- redirect_pc  in  ADDR_WIDTH  redirect target
- id_valid  out  1  IF/ID buffer holds a valid instruction
- id_ready  in  1  decode accepts (low = stall)
- id_instr  out  DATA_WIDTH  buffered instruction
- id_pc  out  ADDR_WIDTH  PC of buffered instruction
- id_pc_plus4  out  ADDR_WIDTH  id_pc + PC_STEP
- fetch_misaligned  out  1  registered; set when a request is issued with pc_in[1:0] != 0

Behaviour:
- Reset (async, active-high) forces the following, regardless of clock:
  - state = FETCH
  - id_valid = 0; id_instr, id_pc, id_pc_plus4 = 0
  - fetch_misaligned = 0
- Outputs pc_enable, imem_req_valid and next_pc are combinational from state and inputs. They are 0 during reset.
- buf_free = !id_valid || id_ready.
- State FETCH:
  - imem_req_valid = buf_free && !redirect_valid.
  - imem_addr = {pc_in[ADDR_WIDTH-1:2], 2'b00}.
  - On handshake (req_valid && req_ready):
    - req_pc <= pc_in.
    - pc_enable = 1, next_pc = pc_in + PC_STEP (mod 2^ADDR_WIDTH; wraps 0xFFFFFFFC -> 0).
    - Go to WAIT.
  - req_ready low: hold the request; pc_in, imem_addr and pc_enable stay stable.
- State WAIT:
  - On imem_resp_valid: id_instr <= data, id_pc <= req_pc, id_pc_plus4 <= req_pc + PC_STEP, id_valid <= 1. Go to FETCH.
  - The buffer is always free at this point, because a request only issues when buf_free.
- State DROP:
  - Waits for the response of a squashed request.
  - On imem_resp_valid: data is discarded and the state goes to FETCH.
- Decode handshake:
  - id_valid && id_ready consumes the entry; id_valid <= 0 unless it is reloaded the same edge.
  - id_* outputs are stable while id_valid && !id_ready.
- Redirect (highest priority, any state):
  - pc_enable = 1, next_pc = redirect_pc.
  - id_valid <= 0; an entry presented that cycle counts as consumed.
  - No new request is issued that cycle.
  - In WAIT → DROP. In DROP → stay DROP. In FETCH → stay FETCH.
  - Redirect with a response in the same cycle while in WAIT/DROP: the response is discarded and the state goes to FETCH.
- Latency: at most one outstanding request.
  - Zero-wait memory (ready=1, response next cycle) gives one instruction per 2 cycles.
  - The PC advances on the request-accept edge.
- Reset mid-WAIT: the in-flight response is ignored. The memory side must also be reset.

Decomposition:
- Shared package mips_fetch_pkg:
  - fetch_state_t enum {FETCH, WAIT, DROP}
  - PC_STEP constant
  - NOP_INSTR = 32'h0000_0000
- Sub-module fetch_buffer: the IF/ID register with load/consume/flush. It holds instr/pc/pc_plus4/valid.

Test Plan:
- Reset asserted → id_valid=0, pc_enable=0, imem_req_valid=0; after release with pc_in=0 → request addr 0x0, next_pc=0x4 with pc_enable=1.
- Zero-wait memory returning 0x20080005 for addr 0x0 and 0x20090007 for 0x4, id_ready=1 → id_pc 0x0 then 0x4, id_pc_plus4 0x4 then 0x8, one instruction every 2 cycles.
- id_ready=0 for 5 cycles with a buffered instr at 0x8 → no new request, id_instr/id_pc held; id_ready=1 → next request to 0xC.
- redirect_valid with redirect_pc=0x100 while in WAIT → next_pc=0x100, id_valid drops, the late response is discarded (never appears on id_instr), and the next request goes to 0x100.
- imem_req_ready low 3 cycles at pc_in=0x10 → req_valid held, pc_enable=0 until accept; at pc_in=0xFFFFFFFC → next_pc=0x0.
- Reset pulse mid-WAIT → id_valid=0, state FETCH; pc_in=0x6 → fetch_misaligned=1 after issue, imem_addr=0x4.
